tt_sweep_ctrl: RTL

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: steps a 4-input gate through all 16 input
// vectors, captures its response and compares it against a latched golden table.
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected_tt,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured_tt,
  output logic [15:0] mismatch_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  // With no settle time each vector goes straight to its sample cycle.
  localparam state_t FIRST_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_index;
  logic [3:0]  r_cnt;
  logic [15:0] r_exp;
  logic [15:0] r_cap;
  logic [15:0] r_mask;
  logic        r_pass;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves the next state unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = FIRST_ST;
      SETTLE: begin
        if (abort)              w_state_nxt = IDLE;
        else if (r_cnt <= 4'd1) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                 w_state_nxt = IDLE;
        else if (r_index == 4'hF)  w_state_nxt = DONE;
        else                       w_state_nxt = FIRST_ST;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= 4'd0;
      r_cnt   <= 4'd0;
      r_exp   <= 16'h0000;
      r_cap   <= 16'h0000;
      r_mask  <= 16'h0000;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_exp   <= expected_tt;
            r_cap   <= 16'h0000;
            r_index <= 4'd0;
            r_cnt   <= SETTLE_LD;
            r_pass  <= 1'b0;
          end
        end
        SETTLE: begin
          if (!abort && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        SAMPLE: begin
          if (!abort) begin
            r_cap[r_index] <= dut_out;
            // Index saturates at 15 so dut_in never wraps back to vector 0.
            if (r_index != 4'hF) begin
              r_index <= r_index + 4'd1;
              r_cnt   <= SETTLE_LD;
            end
          end
        end
        DONE: begin
          r_pass <= (r_cap == r_exp);
          r_mask <= r_cap ^ r_exp;
        end
        default: ;
      endcase
    end
  end

  assign dut_in        = r_index;
  assign busy          = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done          = (r_state == DONE);
  assign pass          = r_pass;
  assign captured_tt   = r_cap;
  assign mismatch_mask = r_mask;

endmodule
